// File: rtl/vga_sync_receiver.sv
// Receiving end of the VGA link: recovers pixel coordinates, line/frame lengths,
// timing lock and a per-frame pixel checksum from sampled hsync/vsync/RGB.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [3:0]  r_i,
    input  logic [3:0]  g_i,
    input  logic [3:0]  b_i,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        pix_valid,
    output logic        locked,
    output logic        frame_done,
    output logic [10:0] h_len,
    output logic [10:0] v_len,
    output logic [15:0] frame_sum,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_ALIGN  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [10:0] CNT_MAX = 11'h7FF;
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] P_LIMIT = 11'(2 * H_TOTAL);
    localparam logic [10:0] H_AS    = 11'(H_ACT_START);
    localparam logic [10:0] H_AE    = 11'(H_ACT_START + H_ACT);
    localparam logic [10:0] V_AS    = 11'(V_ACT_START);
    localparam logic [10:0] V_AE    = 11'(V_ACT_START + V_ACT);

    logic        hs_q, vs_q, hs_p, vs_p;
    logic [11:0] rgb_q;
    logic [10:0] p_cnt, l_cnt, ln_cnt;
    logic        vs_pend;
    logic [1:0]  state, state_nxt;
    logic        good, good_nxt, err_inc;
    logic [15:0] acc;

    logic        hs_fall, vs_fall, h_bad, v_bad, p_timeout, in_window, valid_nxt;
    logic [10:0] p_inc, p_nxt, l_nxt, ln_inc, h_len_nxt, v_len_nxt;

    assign hs_fall = hs_p & ~hs_q;
    assign vs_fall = vs_p & ~vs_q;

    // Position of the sample currently in the input register.
    assign p_inc = (p_cnt == CNT_MAX) ? CNT_MAX : p_cnt + 11'd1;
    assign p_nxt = hs_fall ? 11'd0 : p_inc;

    // The hsync fall is handled first, so a coincident vsync fall still zeroes L.
    assign l_nxt = !hs_fall                ? l_cnt :
                   (vs_pend || vs_fall)    ? 11'd0 :
                   (l_cnt == CNT_MAX)      ? CNT_MAX : l_cnt + 11'd1;

    assign ln_inc    = (hs_fall && ln_cnt != CNT_MAX) ? ln_cnt + 11'd1 : ln_cnt;
    assign h_len_nxt = hs_fall ? p_inc : h_len;
    assign v_len_nxt = vs_fall ? ln_inc : v_len;

    assign h_bad     = hs_fall && (h_len_nxt != H_TOT);
    assign v_bad     = vs_fall && (v_len_nxt != V_TOT);
    assign p_timeout = !hs_fall && (p_nxt == P_LIMIT);

    assign in_window = (p_nxt >= H_AS) && (p_nxt < H_AE) && (l_nxt >= V_AS) && (l_nxt < V_AE);
    assign valid_nxt = in_window && (state == S_LOCKED);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_inc   = 1'b0;
        case (state)
            S_SEARCH: begin
                if (vs_fall) begin
                    state_nxt = S_ALIGN;
                    good_nxt  = 1'b1;
                end
            end
            S_ALIGN: begin
                if (h_bad) good_nxt = 1'b0;
                if (vs_fall) begin
                    if (good_nxt && v_len_nxt == V_TOT) state_nxt = S_LOCKED;
                    good_nxt = 1'b1;
                end
            end
            S_LOCKED: begin
                if (h_bad || v_bad || p_timeout) begin
                    state_nxt = S_SEARCH;
                    err_inc   = 1'b1;
                end
            end
            default: state_nxt = S_SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hs_p       <= 1'b0;
            vs_p       <= 1'b0;
            rgb_q      <= '0;
            p_cnt      <= '0;
            l_cnt      <= '0;
            ln_cnt     <= '0;
            vs_pend    <= 1'b0;
            state      <= S_SEARCH;
            good       <= 1'b0;
            acc        <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            h_len      <= '0;
            v_len      <= '0;
            frame_sum  <= '0;
            err_cnt    <= '0;
        end else begin
            hs_q    <= hsync_i;
            vs_q    <= vsync_i;
            hs_p    <= hs_q;
            vs_p    <= vs_q;
            rgb_q   <= {r_i, g_i, b_i};
            p_cnt   <= p_nxt;
            l_cnt   <= l_nxt;
            ln_cnt  <= vs_fall ? 11'd0 : ln_inc;
            vs_pend <= hs_fall ? 1'b0 : (vs_fall ? 1'b1 : vs_pend);
            state   <= state_nxt;
            good    <= good_nxt;

            pix_x     <= 10'(p_nxt - H_AS);
            pix_y     <= 10'(l_nxt - V_AS);
            pix_rgb   <= rgb_q;
            pix_valid <= valid_nxt;

            h_len <= h_len_nxt;
            v_len <= v_len_nxt;

            // A pixel sampled together with the vsync fall is credited to the new frame.
            if (vs_fall) begin
                frame_sum <= acc;
                acc       <= valid_nxt ? {4'd0, rgb_q} : 16'd0;
            end else if (valid_nxt) begin
                acc <= acc + {4'd0, rgb_q};
            end

            frame_done <= vs_fall && (state_nxt == S_LOCKED);

            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver on a reduced raster: drives a table of
// frames and scoreboards pixels and frame_done results against its own expectations.
module tb_vga_sync_receiver;

    localparam int HT = 40, HAS = 10, HA = 24;
    localparam int VT = 20, VAS = 3, VA = 14;
    localparam int HS_LOW = 4, VS_LINES = 2, NONE = 999;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [3:0]  r_i = '0, g_i = '0, b_i = '0;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic        pix_valid, locked, frame_done;
    logic [10:0] h_len, v_len;
    logic [15:0] frame_sum;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACT(HA),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACT(VA)
    ) dut (
        .clk(clk), .clr(clr), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
        .locked(locked), .frame_done(frame_done), .h_len(h_len), .v_len(v_len),
        .frame_sum(frame_sum), .err_cnt(err_cnt)
    );

    typedef struct {
        int n_lines, bad_line, stall_line, clr_line, white;
        int exp_locked, exp_done, exp_sum, exp_vlen, exp_err, exp_valid, edge_chk;
    } frame_vec_t;

    typedef struct { bit act; int x; int y; logic [11:0] rgb; } pix_exp_t;
    typedef struct { logic [15:0] sum; int hl; int vl; } done_exp_t;

    pix_exp_t  pix_q[$];
    done_exp_t sb_q[$];
    pix_exp_t  pe;
    done_exp_t de;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int valid_cnt = 0, pix_err = 0, xmin = 9999, xmax = -1, ymin = 9999, ymax = -1;
    int lock_rise_cyc = -1, lock_fall_cyc = -1;
    logic lock_prev = 1'b0;
    int frame_start_cyc = 0, evt_cyc = 0;
    frame_vec_t pend;
    bit pend_valid = 1'b0;
    frame_vec_t vecs[13];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pixels trail the pins by two clocks, frame_done pops the scoreboard.
    always @(negedge clk) begin
        if (pix_q.size() >= 3) begin
            pe = pix_q.pop_front();
            if (pix_valid) begin
                valid_cnt++;
                if (!pe.act || int'(pix_x) != pe.x || int'(pix_y) != pe.y || pix_rgb != pe.rgb)
                    pix_err++;
                if (int'(pix_x) < xmin) xmin = int'(pix_x);
                if (int'(pix_x) > xmax) xmax = int'(pix_x);
                if (int'(pix_y) < ymin) ymin = int'(pix_y);
                if (int'(pix_y) > ymax) ymax = int'(pix_y);
            end
        end
        if (locked && !lock_prev) lock_rise_cyc = cyc;
        if (!locked && lock_prev) lock_fall_cyc = cyc;
        lock_prev = locked;
        if (frame_done) begin
            check("done_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                de = sb_q.pop_front();
                check("frame_sum", frame_sum, de.sum);
                check("done_h_len", h_len, de.hl);
                check("done_v_len", v_len, de.vl);
            end
        end
    end

    task automatic drive_clk(input logic hs, input logic vs, input logic [11:0] rgb,
                             input bit act, input int x, input int y, input logic clr_v);
        @(posedge clk);
        #1;
        clr     = clr_v;
        hsync_i = hs;
        vsync_i = vs;
        {r_i, g_i, b_i} = rgb;
        pix_q.push_back('{act: act, x: x, y: y, rgb: rgb});
        @(negedge clk);
    endtask

    // Outcome of the previous frame, observed just after the vsync fall that ends it.
    task automatic frame_hook();
        if (pend_valid) begin
            check("locked", locked, pend.exp_locked);
            check("err_cnt", err_cnt, pend.exp_err);
            check("v_len", v_len, pend.exp_vlen);
            check("h_len", h_len, HT);
            check("done_outstanding", sb_q.size(), 0);
            if (pend.exp_valid >= 0) begin
                check("valid_cnt", valid_cnt, pend.exp_valid);
                check("pix_err", pix_err, 0);
                if (pend.exp_valid == HA * VA) begin
                    check("x_min", xmin, 0);
                    check("x_max", xmax, HA - 1);
                    check("y_min", ymin, 0);
                    check("y_max", ymax, VA - 1);
                end
            end
            if (pend.edge_chk == 1) check("lock_rise_delay", lock_rise_cyc - frame_start_cyc, 2);
            if (pend.edge_chk == 2) check("lock_fall_delay", lock_fall_cyc - evt_cyc, 2);
        end
        valid_cnt = 0; pix_err = 0;
        xmin = 9999; xmax = -1; ymin = 9999; ymax = -1;
    endtask

    task automatic drive_frame(input frame_vec_t v);
        int sum = 0;
        int len, hs_low, x, y;
        bit act;
        logic [11:0] rgb;
        for (int ln = 0; ln < v.n_lines; ln++) begin
            len    = (ln == v.bad_line) ? HT + 1 : (ln == v.stall_line) ? 200 : HT;
            hs_low = (ln == v.stall_line) ? 0 : HS_LOW;
            for (int c = 0; c < len; c++) begin
                x   = c - HAS;
                y   = ln - VAS;
                act = (c >= HAS) && (c < HAS + HA) && (ln >= VAS) && (ln < VAS + VA);
                rgb = !act ? 12'h000 : (v.white != 0) ? 12'hFFF : 12'(x * 37 + y * 101 + 5);
                if (act) sum += int'(rgb);
                drive_clk(c >= hs_low, ln >= VS_LINES, rgb, act, x, y, (ln == v.clr_line) && (c == 20));
                if (c == 0) begin
                    if (ln == 0) frame_start_cyc = cyc;
                    if (ln == v.stall_line - 1) evt_cyc = cyc + 2 * HT;
                    if (ln == v.bad_line + 1) evt_cyc = cyc;
                end
                if (ln == 0 && c == 3) frame_hook();
                if (ln == v.clr_line && c == 21) begin
                    check("clr_pix", {pix_x, pix_y, pix_rgb, pix_valid, frame_done}, 0);
                    check("clr_len_sum", {h_len, v_len, frame_sum}, 0);
                    check("clr_err_lock", {err_cnt, locked}, 0);
                end
            end
        end
        if (v.exp_done != 0)
            sb_q.push_back('{sum: (v.exp_sum < 0) ? 16'(sum) : 16'(v.exp_sum), hl: HT, vl: VT});
        pend       = v;
        pend_valid = 1'b1;
    endtask

    initial begin
        // n_lines bad stall clr white | locked done sum vlen err valid edge
        vecs[0]  = '{20, NONE, NONE, NONE, 0,  1, 1, 0,       20, 0, 0,   1};
        vecs[1]  = '{20, NONE, NONE, NONE, 0,  1, 1, -1,      20, 0, 336, 0};
        // 24*14 pixels of 12'hFFF: 336*4095 mod 2^16 = 16'hFEB0
        vecs[2]  = '{20, NONE, NONE, NONE, 1,  1, 1, 'hFEB0,  20, 0, 336, 0};
        vecs[3]  = '{20, 5,    NONE, NONE, 0,  0, 0, 0,       20, 1, 72,  2};
        vecs[4]  = '{20, NONE, NONE, NONE, 0,  1, 1, 0,       20, 1, 0,   1};
        vecs[5]  = '{20, NONE, NONE, NONE, 0,  1, 1, -1,      20, 1, 336, 0};
        vecs[6]  = '{20, NONE, 10,   NONE, 0,  0, 0, 0,       19, 2, 168, 2};
        vecs[7]  = '{19, NONE, NONE, NONE, 0,  0, 0, 0,       19, 2, 0,   0};
        vecs[8]  = '{20, NONE, NONE, NONE, 0,  1, 1, 0,       20, 2, 0,   1};
        vecs[9]  = '{20, NONE, NONE, NONE, 0,  1, 1, -1,      20, 2, 336, 0};
        vecs[10] = '{20, NONE, NONE, 12,   0,  0, 0, 0,       8,  0, 225, 0};
        vecs[11] = '{20, NONE, NONE, NONE, 0,  1, 1, 0,       20, 0, 0,   1};
        vecs[12] = '{4,  NONE, NONE, NONE, 0,  0, 0, 0,       0,  0, -1,  0};

        for (int i = 0; i < 3; i++) drive_clk(1'b1, 1'b1, 12'h000, 1'b0, 0, 0, 1'b1);
        check("rst_pix", {pix_x, pix_y, pix_rgb, pix_valid, frame_done}, 0);
        check("rst_len_sum", {h_len, v_len, frame_sum}, 0);
        check("rst_err_lock", {err_cnt, locked}, 0);
        for (int i = 0; i < 3; i++) drive_clk(1'b1, 1'b1, 12'h000, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 13; i++) drive_frame(vecs[i]);
        for (int i = 0; i < 5; i++) drive_clk(1'b1, 1'b1, 12'h000, 1'b0, 0, 0, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
